// File: rtl/subshift_stage.sv
`default_nettype none
// ============================================================================
// subshift_stage : two-stage AES SubBytes (S1) + ShiftRows (S2) with valid/ready
// Revision       : 1.0
// ============================================================================
module subshift_stage #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state,
   output logic [TAG_W-1:0] out_tag
);

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      logic [7:0] s;
      s = 8'h00;
      case (b)
         8'h00: s = 8'h63;  8'h01: s = 8'h7c;  8'h02: s = 8'h77;  8'h03: s = 8'h7b;
         8'h04: s = 8'hf2;  8'h05: s = 8'h6b;  8'h06: s = 8'h6f;  8'h07: s = 8'hc5;
         8'h08: s = 8'h30;  8'h09: s = 8'h01;  8'h0a: s = 8'h67;  8'h0b: s = 8'h2b;
         8'h0c: s = 8'hfe;  8'h0d: s = 8'hd7;  8'h0e: s = 8'hab;  8'h0f: s = 8'h76;
         8'h10: s = 8'hca;  8'h11: s = 8'h82;  8'h12: s = 8'hc9;  8'h13: s = 8'h7d;
         8'h14: s = 8'hfa;  8'h15: s = 8'h59;  8'h16: s = 8'h47;  8'h17: s = 8'hf0;
         8'h18: s = 8'had;  8'h19: s = 8'hd4;  8'h1a: s = 8'ha2;  8'h1b: s = 8'haf;
         8'h1c: s = 8'h9c;  8'h1d: s = 8'ha4;  8'h1e: s = 8'h72;  8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7;  8'h21: s = 8'hfd;  8'h22: s = 8'h93;  8'h23: s = 8'h26;
         8'h24: s = 8'h36;  8'h25: s = 8'h3f;  8'h26: s = 8'hf7;  8'h27: s = 8'hcc;
         8'h28: s = 8'h34;  8'h29: s = 8'ha5;  8'h2a: s = 8'he5;  8'h2b: s = 8'hf1;
         8'h2c: s = 8'h71;  8'h2d: s = 8'hd8;  8'h2e: s = 8'h31;  8'h2f: s = 8'h15;
         8'h30: s = 8'h04;  8'h31: s = 8'hc7;  8'h32: s = 8'h23;  8'h33: s = 8'hc3;
         8'h34: s = 8'h18;  8'h35: s = 8'h96;  8'h36: s = 8'h05;  8'h37: s = 8'h9a;
         8'h38: s = 8'h07;  8'h39: s = 8'h12;  8'h3a: s = 8'h80;  8'h3b: s = 8'he2;
         8'h3c: s = 8'heb;  8'h3d: s = 8'h27;  8'h3e: s = 8'hb2;  8'h3f: s = 8'h75;
         8'h40: s = 8'h09;  8'h41: s = 8'h83;  8'h42: s = 8'h2c;  8'h43: s = 8'h1a;
         8'h44: s = 8'h1b;  8'h45: s = 8'h6e;  8'h46: s = 8'h5a;  8'h47: s = 8'ha0;
         8'h48: s = 8'h52;  8'h49: s = 8'h3b;  8'h4a: s = 8'hd6;  8'h4b: s = 8'hb3;
         8'h4c: s = 8'h29;  8'h4d: s = 8'he3;  8'h4e: s = 8'h2f;  8'h4f: s = 8'h84;
         8'h50: s = 8'h53;  8'h51: s = 8'hd1;  8'h52: s = 8'h00;  8'h53: s = 8'hed;
         8'h54: s = 8'h20;  8'h55: s = 8'hfc;  8'h56: s = 8'hb1;  8'h57: s = 8'h5b;
         8'h58: s = 8'h6a;  8'h59: s = 8'hcb;  8'h5a: s = 8'hbe;  8'h5b: s = 8'h39;
         8'h5c: s = 8'h4a;  8'h5d: s = 8'h4c;  8'h5e: s = 8'h58;  8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0;  8'h61: s = 8'hef;  8'h62: s = 8'haa;  8'h63: s = 8'hfb;
         8'h64: s = 8'h43;  8'h65: s = 8'h4d;  8'h66: s = 8'h33;  8'h67: s = 8'h85;
         8'h68: s = 8'h45;  8'h69: s = 8'hf9;  8'h6a: s = 8'h02;  8'h6b: s = 8'h7f;
         8'h6c: s = 8'h50;  8'h6d: s = 8'h3c;  8'h6e: s = 8'h9f;  8'h6f: s = 8'ha8;
         8'h70: s = 8'h51;  8'h71: s = 8'ha3;  8'h72: s = 8'h40;  8'h73: s = 8'h8f;
         8'h74: s = 8'h92;  8'h75: s = 8'h9d;  8'h76: s = 8'h38;  8'h77: s = 8'hf5;
         8'h78: s = 8'hbc;  8'h79: s = 8'hb6;  8'h7a: s = 8'hda;  8'h7b: s = 8'h21;
         8'h7c: s = 8'h10;  8'h7d: s = 8'hff;  8'h7e: s = 8'hf3;  8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd;  8'h81: s = 8'h0c;  8'h82: s = 8'h13;  8'h83: s = 8'hec;
         8'h84: s = 8'h5f;  8'h85: s = 8'h97;  8'h86: s = 8'h44;  8'h87: s = 8'h17;
         8'h88: s = 8'hc4;  8'h89: s = 8'ha7;  8'h8a: s = 8'h7e;  8'h8b: s = 8'h3d;
         8'h8c: s = 8'h64;  8'h8d: s = 8'h5d;  8'h8e: s = 8'h19;  8'h8f: s = 8'h73;
         8'h90: s = 8'h60;  8'h91: s = 8'h81;  8'h92: s = 8'h4f;  8'h93: s = 8'hdc;
         8'h94: s = 8'h22;  8'h95: s = 8'h2a;  8'h96: s = 8'h90;  8'h97: s = 8'h88;
         8'h98: s = 8'h46;  8'h99: s = 8'hee;  8'h9a: s = 8'hb8;  8'h9b: s = 8'h14;
         8'h9c: s = 8'hde;  8'h9d: s = 8'h5e;  8'h9e: s = 8'h0b;  8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0;  8'ha1: s = 8'h32;  8'ha2: s = 8'h3a;  8'ha3: s = 8'h0a;
         8'ha4: s = 8'h49;  8'ha5: s = 8'h06;  8'ha6: s = 8'h24;  8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2;  8'ha9: s = 8'hd3;  8'haa: s = 8'hac;  8'hab: s = 8'h62;
         8'hac: s = 8'h91;  8'had: s = 8'h95;  8'hae: s = 8'he4;  8'haf: s = 8'h79;
         8'hb0: s = 8'he7;  8'hb1: s = 8'hc8;  8'hb2: s = 8'h37;  8'hb3: s = 8'h6d;
         8'hb4: s = 8'h8d;  8'hb5: s = 8'hd5;  8'hb6: s = 8'h4e;  8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c;  8'hb9: s = 8'h56;  8'hba: s = 8'hf4;  8'hbb: s = 8'hea;
         8'hbc: s = 8'h65;  8'hbd: s = 8'h7a;  8'hbe: s = 8'hae;  8'hbf: s = 8'h08;
         8'hc0: s = 8'hba;  8'hc1: s = 8'h78;  8'hc2: s = 8'h25;  8'hc3: s = 8'h2e;
         8'hc4: s = 8'h1c;  8'hc5: s = 8'ha6;  8'hc6: s = 8'hb4;  8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8;  8'hc9: s = 8'hdd;  8'hca: s = 8'h74;  8'hcb: s = 8'h1f;
         8'hcc: s = 8'h4b;  8'hcd: s = 8'hbd;  8'hce: s = 8'h8b;  8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70;  8'hd1: s = 8'h3e;  8'hd2: s = 8'hb5;  8'hd3: s = 8'h66;
         8'hd4: s = 8'h48;  8'hd5: s = 8'h03;  8'hd6: s = 8'hf6;  8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61;  8'hd9: s = 8'h35;  8'hda: s = 8'h57;  8'hdb: s = 8'hb9;
         8'hdc: s = 8'h86;  8'hdd: s = 8'hc1;  8'hde: s = 8'h1d;  8'hdf: s = 8'h9e;
         8'he0: s = 8'he1;  8'he1: s = 8'hf8;  8'he2: s = 8'h98;  8'he3: s = 8'h11;
         8'he4: s = 8'h69;  8'he5: s = 8'hd9;  8'he6: s = 8'h8e;  8'he7: s = 8'h94;
         8'he8: s = 8'h9b;  8'he9: s = 8'h1e;  8'hea: s = 8'h87;  8'heb: s = 8'he9;
         8'hec: s = 8'hce;  8'hed: s = 8'h55;  8'hee: s = 8'h28;  8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c;  8'hf1: s = 8'ha1;  8'hf2: s = 8'h89;  8'hf3: s = 8'h0d;
         8'hf4: s = 8'hbf;  8'hf5: s = 8'he6;  8'hf6: s = 8'h42;  8'hf7: s = 8'h68;
         8'hf8: s = 8'h41;  8'hf9: s = 8'h99;  8'hfa: s = 8'h2d;  8'hfb: s = 8'h0f;
         8'hfc: s = 8'hb0;  8'hfd: s = 8'h54;  8'hfe: s = 8'hbb;  8'hff: s = 8'h16;
      endcase
      return s;
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [127:0]     s1_state_q, s1_state_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic [127:0]     s2_state_q, s2_state_d;
   logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

   logic [127:0]     w_sub_state;
   logic [127:0]     w_shift_state;
   logic             w_adv1;
   logic             w_adv2;

   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign w_sub_state[i*8 +: 8] = sbox_fwd(in_state[i*8 +: 8]);
   end

   // Row r of the output takes column (c+r) mod 4 of the same row in S1.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_shift_state[(4*c+r)*8 +: 8] = s1_state_q[(4*((c+r)%4)+r)*8 +: 8];
      end
   end

   assign w_adv2   = !s2_valid_q || out_ready;
   assign w_adv1   = !s1_valid_q || w_adv2;
   assign in_ready = w_adv1;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_state_d = s1_state_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_state_d = s2_state_q;
      s2_tag_d   = s2_tag_q;
      if (w_adv1) begin
         s1_valid_d = in_valid;
         s1_state_d = w_sub_state;
         s1_tag_d   = in_tag;
      end
      if (w_adv2) begin
         s2_valid_d = s1_valid_q;
         s2_state_d = w_shift_state;
         s2_tag_d   = s1_tag_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_state_q <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_state_q <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_state_q <= s1_state_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_state_q <= s2_state_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_state = s2_state_q;
   assign out_tag   = s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_subshift_stage.sv
`default_nettype none
// ============================================================================
// tb_subshift_stage : randomized bench for subshift_stage against an algebraic AES model
// Revision          : 1.0
// ============================================================================
module tb_subshift_stage;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [3:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic [3:0]   out_tag;

   subshift_stage #(.TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   sbox_ref [256];
   logic [131:0] exp_q [$];
   logic         stall_seen = 1'b0;
   logic [131:0] held = '0;

   task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_ref[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_f(input logic [127:0] st);
      logic [7:0]   m [4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) m[r][c] = sbox_ref[st[(4*c+r)*8 +: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[(4*c+r)*8 +: 8] = m[r][(c + r) % 4];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard: queue depth equals pipeline occupancy, so in_ready is predictable from it.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_seen = 1'b0;
      end else begin
         check("in_ready", 132'(in_ready), 132'(!(exp_q.size() == 2 && !out_ready)));
         if (stall_seen) begin
            check("hold_valid", 132'(out_valid), 132'd1);
            check("hold_data", {out_tag, out_state}, held);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 132'(exp_q.size()), 132'd1);
            else                   check("sb_data", {out_tag, out_state}, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back({in_tag, ref_f(in_state)});
         stall_seen = out_valid && !out_ready;
         held       = {out_tag, out_state};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic uniform(input logic [7:0] b, input logic [7:0] e);
      logic [127:0] exp_st = {16{e}};
      in_state = {16{b}};
      in_tag   = b[3:0];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("uniform", {out_tag, out_state}, {b[3:0], exp_st});
   endtask

   initial begin
      int acc;
      build_sbox();
      rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 132'(out_valid), 132'd0);
      check("rst_data", {out_tag, out_state}, 132'd0);
      check("rst_ready", 132'(in_ready), 132'd1);
      rst_n = 1'b1;

      out_ready = 1'b1;
      in_state  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
      in_tag    = 4'h1;
      in_valid  = 1'b1;
      tick();
      check("fips_lat1", 132'(out_valid), 132'd0);
      in_valid = 1'b0;
      tick();
      check("fips_lat2", 132'(out_valid), 132'd1);
      check("fips_data", {out_tag, out_state}, {4'h1, 128'he598271ef11141b8ae52b4e0305dbfd4});

      uniform(8'h00, 8'h63);
      uniform(8'h53, 8'hed);
      uniform(8'hff, 8'h16);

      for (int g = 0; g < 16; g++) begin
         for (int k = 0; k < 16; k++) in_state[k*8 +: 8] = 8'(g * 16 + k);
         in_tag   = 4'(g);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();

      for (int i = 0; i < 100; i++) begin
         in_state = rand128();
         in_tag   = 4'($urandom);
         in_valid = 1'b1;
         tick();
         if (i >= 1) check("stream_valid", 132'(out_valid), 132'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_last", 132'(out_valid), 132'd1);
      tick();
      check("stream_done", 132'(out_valid), 132'd0);
      check("stream_empty", 132'(exp_q.size()), 132'd0);

      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         in_state = rand128();
         in_tag   = 4'($urandom);
         in_valid = 1'b1;
         if (in_ready) acc++;
         tick();
      end
      check("bp_accepts", 132'(acc), 132'd2);
      check("bp_ready", 132'(in_ready), 132'd0);
      check("bp_valid", 132'(out_valid), 132'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_second", 132'(out_valid), 132'd1);
      tick();
      check("bp_drained", 132'(out_valid), 132'd0);
      check("bp_empty", 132'(exp_q.size()), 132'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = rand128();
      in_tag    = 4'hA;
      tick();
      in_state  = rand128();
      in_tag    = 4'h5;
      tick();
      in_valid = 1'b0;
      check("mid_full", 132'(in_ready), 132'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 132'(out_valid), 132'd0);
      check("mid_rst_data", {out_tag, out_state}, 132'd0);
      check("mid_rst_ready", 132'(in_ready), 132'd1);
      tick();
      rst_n = 1'b1;
      check("mid_post_ready", 132'(in_ready), 132'd1);

      for (int i = 0; i < 2000; i++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_state  = rand128();
         in_tag    = 4'($urandom);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("final_empty", 132'(exp_q.size()), 132'd0);
      check("final_valid", 132'(out_valid), 132'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
